// File: rtl/rmac_lanes_if.sv
// Handshake and lane buses between the fetch stage, the rmac_lanes block and the output buffer.
interface rmac_lanes_if #(
    parameter int L = 4,
    parameter int n = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [L*n-1:0] W;
    logic [L*n-1:0] X;
    logic           out_valid;
    logic           out_ready;
    logic [L*n-1:0] sum;
    logic [L-1:0]   ovf;

    modport master (output in_valid, W, X, out_ready,
                    input  in_ready, out_valid, sum, ovf);
    modport slave  (input  in_valid, W, X, out_ready,
                    output in_ready, out_valid, sum, ovf);
endinterface

// File: rtl/rmac_lanes.sv
// L-lane sign-magnitude saturating MAC over S beats; result valid the cycle after the S-th beat, held
// until out_ready (inputs back-pressured meanwhile, drain+accept same cycle). RMAC_RELU_EN adds ReLU on sum.
module rmac_lanes #(
    parameter int L        = 4,
    parameter int S        = 8,
    parameter int n        = 32,
    parameter int intbits  = 12,
    parameter int fracbits = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    rmac_lanes_if.slave bus
);
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam int FB = (intbits + fracbits == n) ? fracbits : n - intbits;
    localparam logic [n-2:0] MAG_MAX = '1;

    typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_base;
    logic [n-1:0]   psum [L];
    logic [L-1:0]   sticky, sticky_nxt;
    logic [L*n-1:0] sum_q, sum_nxt;
    logic [L-1:0]   ovf_q;
    logic [n:0]     prod_r [L];
    logic [n:0]     acc_r  [L];
    logic           accept, drain, last, in_rdy;

    // {overflow, sign-magnitude product}; a zero magnitude never carries a sign
    function automatic logic [n:0] mul_sm(input logic [n-1:0] w, input logic [n-1:0] x);
        logic [2*n-3:0] prod;
        logic [n-2:0]   mag;
        logic           sat;
        prod = {{(n-1){1'b0}}, w[n-2:0]} * {{(n-1){1'b0}}, x[n-2:0]};
        prod = prod >> FB;
        sat  = |prod[2*n-3:n-1];
        mag  = sat ? MAG_MAX : prod[n-2:0];
        return {sat, (mag != '0) & (w[n-1] ^ x[n-1]), mag};
    endfunction

    // {overflow, sign-magnitude a + b}
    function automatic logic [n:0] acc_sm(input logic [n-1:0] a, input logic [n-1:0] b);
        logic [n-1:0] s;
        logic [n-2:0] ma, mb;
        ma = a[n-2:0];
        mb = b[n-2:0];
        s  = {1'b0, ma} + {1'b0, mb};
        if (a[n-1] == b[n-1])
            return s[n-1] ? {1'b1, a[n-1], MAG_MAX} : {1'b0, a[n-1], s[n-2:0]};
        if (ma > mb) return {1'b0, a[n-1], ma - mb};
        if (mb > ma) return {1'b0, b[n-1], mb - ma};
        return '0;
    endfunction

    always_comb begin
        drain     = (state == DONE) && bus.out_ready;
        in_rdy    = reset_n && ((state == ACC) || drain);
        accept    = bus.in_valid && in_rdy;
        cnt_base  = drain ? '0 : cnt;
        last      = (cnt_base == CW'(S - 1));
        state_nxt = state;
        if (accept && last)
            state_nxt = DONE;
        else if (drain)
            state_nxt = ACC;
    end

    // A draining cycle accumulates on top of a cleared psum so back-to-back results need no bubble
    always_comb begin
        sticky_nxt = '0;
        sum_nxt    = '0;
        for (int i = 0; i < L; i++) begin
            prod_r[i]     = mul_sm(bus.W[i*n +: n], bus.X[i*n +: n]);
            acc_r[i]      = acc_sm(drain ? '0 : psum[i], prod_r[i][n-1:0]);
            sticky_nxt[i] = (sticky[i] & ~drain) | prod_r[i][n] | acc_r[i][n];
`ifdef RMAC_RELU_EN
            sum_nxt[i*n +: n] = acc_r[i][n-1] ? '0 : acc_r[i][n-1:0];
`else
            sum_nxt[i*n +: n] = acc_r[i][n-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ACC;
            cnt    <= '0;
            sticky <= '0;
            sum_q  <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < L; i++) psum[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= last ? '0 : cnt_base + CW'(1);
                sticky <= sticky_nxt;
                for (int i = 0; i < L; i++) psum[i] <= acc_r[i][n-1:0];
                if (last) begin
                    sum_q <= sum_nxt;
                    ovf_q <= sticky_nxt;
                end
            end else if (drain) begin
                cnt    <= '0;
                sticky <= '0;
                for (int i = 0; i < L; i++) psum[i] <= '0;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rmac_lanes.sv
// Directed vector bench for rmac_lanes (L=4, S=8, n=32, fracbits=20); honours RMAC_RELU_EN.
module tb_rmac_lanes;
    localparam logic [31:0] ONE  = 32'h0010_0000;
    localparam logic [31:0] NONE = 32'h8010_0000;
    localparam logic [31:0] TWO  = 32'h0020_0000;
    localparam logic [31:0] NTWO = 32'h8020_0000;
    localparam logic [31:0] HALF = 32'h0008_0000;

    typedef struct {
        logic [127:0] we, xe, wo, xo;
        logic [127:0] es;
        logic [3:0]   eo;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   applied = 0;
    int   miscompares = 0;
    vec_t vecs [5];

    rmac_lanes_if #(.L(4), .n(32)) bus ();

    rmac_lanes #(.L(4), .S(8), .n(32), .intbits(12), .fracbits(20)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pk(input logic [31:0] a0, input logic [31:0] a1,
                                        input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] v);
`ifdef RMAC_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_sum(input string nm, input logic [31:0] exp);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s.sum%0d", nm, i), bus.sum[i*32 +: 32], exp);
    endtask

    // Drives count beats with the same W/X on every lane; ends on a negedge with in_valid low
    task automatic beats(input logic [31:0] w, input logic [31:0] x, input int count);
        for (int b = 0; b < count; b++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.W = {4{w}};
            bus.X = {4{x}};
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE),
                    pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE),
                    pk(32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000), 4'b0000};
        vecs[1] = '{pk(ONE, NONE, 32'h0, HALF), pk(NONE, NONE, ONE, TWO),
                    pk(ONE, NONE, 32'h0, HALF), pk(NONE, NONE, ONE, TWO),
                    pk(rl(32'h8080_0000), 32'h0080_0000, 32'h0, 32'h0080_0000), 4'b0000};
        vecs[2] = '{pk(TWO, TWO, TWO, TWO), pk(ONE, ONE, ONE, ONE),
                    pk(NTWO, NTWO, NTWO, NTWO), pk(ONE, ONE, ONE, ONE),
                    pk(32'h0, 32'h0, 32'h0, 32'h0), 4'b0000};
        vecs[3] = '{pk(32'h7FF0_0000, 32'hFFF0_0000, ONE, 32'h4000_0000),
                    pk(32'h7FF0_0000, 32'h7FF0_0000, ONE, ONE),
                    pk(32'h7FF0_0000, 32'hFFF0_0000, ONE, 32'h4000_0000),
                    pk(32'h7FF0_0000, 32'h7FF0_0000, ONE, ONE),
                    pk(32'h7FFF_FFFF, rl(32'hFFFF_FFFF), 32'h0080_0000, 32'h7FFF_FFFF), 4'b1011};
        vecs[4] = '{pk(32'h8000_0001, 32'h0018_0000, 32'h8030_0000, ONE),
                    pk(32'h0000_0001, 32'h0018_0000, 32'h0004_0000, ONE),
                    pk(32'h8000_0001, 32'h0018_0000, 32'h8030_0000, 32'h8030_0000),
                    pk(32'h0000_0001, 32'h0018_0000, 32'h0004_0000, ONE),
                    pk(32'h0, 32'h0120_0000, rl(32'h8060_0000), rl(32'h8080_0000)), 4'b0000};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.W = '0;
        bus.X = '0;

        repeat (2) @(negedge clk);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.ovf", 32'(bus.ovf), 32'd0);
        chk_sum("rst", 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                if (b == 7) chk($sformatf("v%0d.early_valid", v), 32'(bus.out_valid), 32'd0);
                bus.in_valid = 1'b1;
                bus.W = b[0] ? vecs[v].wo : vecs[v].we;
                bus.X = b[0] ? vecs[v].xo : vecs[v].xe;
                @(posedge clk);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d.out_valid", v), 32'(bus.out_valid), 32'd1);
            for (int i = 0; i < 4; i++)
                chk($sformatf("v%0d.sum%0d", v, i), bus.sum[i*32 +: 32], vecs[v].es[i*32 +: 32]);
            chk($sformatf("v%0d.ovf", v), 32'(bus.ovf), 32'(vecs[v].eo));
            @(negedge clk);
            chk($sformatf("v%0d.drained", v), 32'(bus.out_valid), 32'd0);
        end

        // Stall in DONE with a beat waiting, then drain and accept in the same cycle
        bus.out_ready = 1'b0;
        beats(ONE, ONE, 8);
        bus.in_valid = 1'b1;
        bus.W = {4{TWO}};
        bus.X = {4{TWO}};
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("stall%0d.in_ready", c), 32'(bus.in_ready), 32'd0);
            chk($sformatf("stall%0d.out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d.sum0", c), bus.sum[31:0], 32'h0080_0000);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("drain.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            chk($sformatf("nobubble%0d.out_valid", b), 32'(bus.out_valid), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("nobubble.out_valid", 32'(bus.out_valid), 32'd1);
        chk_sum("nobubble", 32'h0200_0000);
        @(negedge clk);

        // Reset in the middle of an accumulation discards the partial sums
        beats(ONE, ONE, 4);
        reset_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst.in_ready", 32'(bus.in_ready), 32'd0);
        chk_sum("midrst", 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        beats(HALF, ONE, 4);
        chk("postrst4.out_valid", 32'(bus.out_valid), 32'd0);
        beats(HALF, ONE, 4);
        chk("postrst8.out_valid", 32'(bus.out_valid), 32'd1);
        chk_sum("postrst", 32'h0040_0000);
        chk("postrst.ovf", 32'(bus.ovf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
